mmu_result_collector: RTL and testbench

//  Consumes the 4x4 systolic MMU result columns (4 data/valid pairs, staggered one cycle apart)
//  and re-emits the 16-word result matrix as an AXI4-Stream master in row-major order for the DMA S2MM path.

---
 rtl/mmu_pkg.sv | 16 +
 rtl/result_bank.sv | 25 ++
 rtl/mmu_result_collector.sv | 191 +++++++++++++++++++
 tb/tb_mmu_result_collector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared constants, drain state type and row-mapping helper for the MMU result collector.
package mmu_pkg;
    localparam int MMU_DIM    = 4;
    localparam int MMU_WORDS  = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE,
        STREAM
    } collector_state_t;

    // With reversed rows the k-th beat on a column belongs to row 3-k.
    function automatic logic [1:0] rowOf(input logic [1:0] beat, input bit rev);
        return rev ? ~beat : beat;
    endfunction
endpackage

// File: rtl/result_bank.sv
// One 4x4 result buffer: a write lane per column (each column owns its own cells) and one combinational read port.
module result_bank
    import mmu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                             i_clk,
    input  logic [MMU_DIM-1:0]               i_we,
    input  logic [MMU_DIM-1:0][1:0]          i_row,
    input  logic [MMU_DIM-1:0][DATA_W-1:0]   i_data,
    input  logic [3:0]                       i_rdIdx,
    output logic [DATA_W-1:0]                o_rdData
);
    logic [DATA_W-1:0] r_mem [MMU_DIM][MMU_DIM];

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < MMU_DIM; c++) begin
            if (i_we[c]) begin
                r_mem[i_row[c]][c] <= i_data[c];
            end
        end
    end

    assign o_rdData = r_mem[i_rdIdx[3:2]][i_rdIdx[1:0]];
endmodule

// File: rtl/mmu_result_collector.sv
// Captures staggered MMU result columns into ping-pong banks and drains each full bank as a row-major AXI4-Stream.
module mmu_result_collector
    import mmu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit REV_ROWS = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    input  logic [DATA_W-1:0] i_data4,
    input  logic              i_valid1,
    input  logic              i_valid2,
    input  logic              i_valid3,
    input  logic              i_valid4,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_overflow
);
    logic [MMU_DIM-1:0][DATA_W-1:0] w_colData;
    logic [MMU_DIM-1:0]             w_colValid;
    logic [MMU_DIM-1:0][1:0]        r_rc;
    logic [MMU_DIM-1:0]             r_done;
    logic [1:0]                     r_full;
    logic                           r_wrBank;
    logic                           r_rdBank;
    collector_state_t               r_state;
    logic [3:0]                     r_idx;
    logic [DATA_W-1:0]              r_tdata;
    logic                           r_tvalid;
    logic                           r_tlast;
    logic                           r_ready;
    logic                           r_overflow;

    logic                           w_handshake;
    logic                           w_release;
    logic                           w_bankFree;
    logic [MMU_DIM-1:0]             w_accept;
    logic                           w_drop;
    logic [MMU_DIM-1:0][1:0]        w_row;
    logic [MMU_DIM-1:0]             w_beatDone;
    logic                           w_doneAll;
    logic [1:0]                     w_fullNext;
    logic                           w_wrBankNext;
    logic [MMU_DIM-1:0]             w_we0;
    logic [MMU_DIM-1:0]             w_we1;
    logic                           w_rdSel;
    logic [3:0]                     w_rdIdx;
    logic [DATA_W-1:0]              w_bank0Data;
    logic [DATA_W-1:0]              w_bank1Data;
    logic [DATA_W-1:0]              w_rdData;

    assign w_colData   = {i_data4, i_data3, i_data2, i_data1};
    assign w_colValid  = {i_valid4, i_valid3, i_valid2, i_valid1};
    assign w_handshake = r_tvalid && m_axis_tready;
    assign w_release   = (r_state == STREAM) && w_handshake && (r_idx == 4'd15);

    // A bank being released on this edge may already take the first beats of the next matrix.
    always_comb begin
        w_row      = '0;
        w_beatDone = '0;
        w_bankFree = !r_full[r_wrBank] || (w_release && (r_rdBank == r_wrBank));
        w_accept   = w_colValid & {MMU_DIM{w_bankFree}};
        w_drop     = |(w_colValid & ~w_accept);
        for (int c = 0; c < MMU_DIM; c++) begin
            w_row[c]      = rowOf(r_rc[c], REV_ROWS);
            w_beatDone[c] = w_accept[c] && (r_rc[c] == 2'd3);
        end
        w_doneAll  = &(r_done | w_beatDone);
        w_fullNext = r_full;
        if (w_release) w_fullNext[r_rdBank] = 1'b0;
        if (w_doneAll) w_fullNext[r_wrBank] = 1'b1;
        w_wrBankNext = r_wrBank ^ w_doneAll;
    end

    assign w_we0 = w_accept & {MMU_DIM{~r_wrBank}};
    assign w_we1 = w_accept & {MMU_DIM{r_wrBank}};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rc       <= '0;
            r_done     <= '0;
            r_full     <= '0;
            r_wrBank   <= 1'b0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < MMU_DIM; c++) begin
                if (w_accept[c]) r_rc[c] <= r_rc[c] + 2'd1;
            end
            r_done     <= w_doneAll ? '0 : (r_done | w_beatDone);
            r_full     <= w_fullNext;
            r_wrBank   <= w_wrBankNext;
            r_ready    <= !w_fullNext[w_wrBankNext];
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Address of the word the output register loads on this edge.
    always_comb begin
        w_rdSel = r_rdBank;
        w_rdIdx = r_idx;
        if (r_state == IDLE) begin
            w_rdIdx = '0;
        end else if (w_handshake) begin
            if (r_idx == 4'd15) begin
                w_rdSel = ~r_rdBank;
                w_rdIdx = '0;
            end else begin
                w_rdIdx = r_idx + 4'd1;
            end
        end
    end

    result_bank #(.DATA_W(DATA_W)) u_bank0 (
        .i_clk    (i_clk),
        .i_we     (w_we0),
        .i_row    (w_row),
        .i_data   (w_colData),
        .i_rdIdx  (w_rdIdx),
        .o_rdData (w_bank0Data)
    );

    result_bank #(.DATA_W(DATA_W)) u_bank1 (
        .i_clk    (i_clk),
        .i_we     (w_we1),
        .i_row    (w_row),
        .i_data   (w_colData),
        .i_rdIdx  (w_rdIdx),
        .o_rdData (w_bank1Data)
    );

    assign w_rdData = w_rdSel ? w_bank1Data : w_bank0Data;

    // Back-to-back matrices chain without a bubble when the other bank is already full at the last handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_rdBank <= 1'b0;
            r_idx    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_full[r_rdBank]) begin
                        r_state  <= STREAM;
                        r_idx    <= '0;
                        r_tdata  <= w_rdData;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (w_handshake) begin
                        if (r_idx == 4'd15) begin
                            r_rdBank <= ~r_rdBank;
                            r_tlast  <= 1'b0;
                            r_idx    <= '0;
                            if (r_full[~r_rdBank]) begin
                                r_tdata <= w_rdData;
                            end else begin
                                r_state  <= IDLE;
                                r_tvalid <= 1'b0;
                            end
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_tdata <= w_rdData;
                            r_tlast <= (r_idx == 4'd14);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign o_ready       = r_ready;
    assign o_overflow    = r_overflow;
    assign o_busy        = (r_state == STREAM) || (|r_done) || (|r_rc);
endmodule

// File: tb/tb_mmu_result_collector.sv
// Directed-random bench: matrices go in as staggered columns and must come out row-major, matching a queue model.
module tb_mmu_result_collector;
    localparam int DW = 32;
    typedef logic [DW-1:0] mat_t [16];

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [DW-1:0] dIn [4];
    logic [3:0]    vIn;
    logic          tready;

    logic [DW-1:0] aData, bData;
    logic          aValid, aLast, aReady, aBusy, aOvf;
    logic          bValid, bLast, bReady, bBusy, bOvf;

    int cyc = 0;
    int nChecks = 0;
    int nFail = 0;
    int readyMode = 0;

    logic [DW-1:0] obsA [$];
    logic [DW-1:0] obsB [$];
    logic          lastA [$];
    logic          lastB [$];
    int            cycA [$];
    logic [DW-1:0] expQ [$];

    logic [DW-1:0] heldA;
    logic          heldLastA;
    logic          stallA = 1'b0;

    mmu_result_collector #(.DATA_W(DW), .REV_ROWS(1'b0)) dutA (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_data1(dIn[0]), .i_data2(dIn[1]), .i_data3(dIn[2]), .i_data4(dIn[3]),
        .i_valid1(vIn[0]), .i_valid2(vIn[1]), .i_valid3(vIn[2]), .i_valid4(vIn[3]),
        .m_axis_tdata(aData), .m_axis_tvalid(aValid), .m_axis_tready(tready),
        .m_axis_tlast(aLast), .o_ready(aReady), .o_busy(aBusy), .o_overflow(aOvf)
    );

    mmu_result_collector #(.DATA_W(DW), .REV_ROWS(1'b1)) dutB (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_data1(dIn[0]), .i_data2(dIn[1]), .i_data3(dIn[2]), .i_data4(dIn[3]),
        .i_valid1(vIn[0]), .i_valid2(vIn[1]), .i_valid3(vIn[2]), .i_valid4(vIn[3]),
        .m_axis_tdata(bData), .m_axis_tvalid(bValid), .m_axis_tready(tready),
        .m_axis_tlast(bLast), .o_ready(bReady), .o_busy(bBusy), .o_overflow(bOvf)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        nChecks++;
        assert (got === want) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkBit(input string tag, input logic got, input logic want);
        nChecks++;
        assert (got === want) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // Handshakes are recorded at the falling edge; a stalled word must not change until it is taken.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            stallA <= 1'b0;
        end else begin
            if (stallA) begin
                checkOutput("stall_tdata", aData, heldA);
                checkBit("stall_tlast", aLast, heldLastA);
            end
            if (aValid && tready) begin
                obsA.push_back(aData);
                lastA.push_back(aLast);
                cycA.push_back(cyc);
            end
            if (bValid && tready) begin
                obsB.push_back(bData);
                lastB.push_back(bLast);
            end
            stallA    <= aValid && !tready;
            heldA     <= aData;
            heldLastA <= aLast;
        end
    end

    function automatic mat_t randomMatrix();
        mat_t m;
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        return m;
    endfunction

    // Column c carries its k-th beat at cycle c+k; the beat holds row k, or row 3-k when revFeed is set.
    task automatic applyStimulus(input mat_t m, input bit revFeed);
        for (int t = 0; t < 7; t++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                int row;
                k = t - c;
                if (k >= 0 && k < 4) begin
                    row    = revFeed ? 3 - k : k;
                    vIn[c] = 1'b1;
                    dIn[c] = m[row * 4 + c];
                end else begin
                    vIn[c] = 1'b0;
                    dIn[c] = $urandom;
                end
            end
            @(posedge i_clk); #1;
        end
        vIn = '0;
    endtask

    task automatic expectMatrix(input mat_t m);
        for (int i = 0; i < 16; i++) expQ.push_back(m[i]);
    endtask

    task automatic doReset();
        i_rst = 1'b0;
        vIn = '0;
        tready = 1'b0;
        readyMode = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        obsA.delete(); obsB.delete(); lastA.delete(); lastB.delete(); cycA.delete(); expQ.delete();
    endtask

    task automatic checkStream(input string tag, input bit useB);
        int waited = 0;
        while ((useB ? obsB.size() : obsA.size()) < expQ.size() && waited < 1000) begin
            @(posedge i_clk); #1;
            if (readyMode == 1) tready = ~tready;
            waited++;
        end
        tready = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        checkOutput({tag, "_count"}, DW'(useB ? obsB.size() : obsA.size()), DW'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < (useB ? obsB.size() : obsA.size())) begin
                checkOutput({tag, "_word"}, useB ? obsB[i] : obsA[i], expQ[i]);
                checkBit({tag, "_tlast"}, useB ? lastB[i] : lastA[i], (i % 16) == 15);
            end
        end
    endtask

    initial begin
        mat_t m;
        mat_t m2;
        mat_t mats [3];
        int held;
        int waited;

        vIn = '0;
        tready = 1'b0;
        for (int c = 0; c < 4; c++) dIn[c] = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checkBit("rst_tvalid", aValid, 1'b0);
        checkBit("rst_tlast", aLast, 1'b0);
        checkOutput("rst_tdata", aData, '0);
        checkBit("rst_ready", aReady, 1'b0);
        checkBit("rst_busy", aBusy, 1'b0);
        checkBit("rst_overflow", aOvf, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checkBit("idle_ready", aReady, 1'b1);
        checkBit("idle_busy", aBusy, 1'b0);

        $display("[TB] single matrix, latency");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r * 4 + c] = DW'(16 * r + c);
        expectMatrix(m);
        tready = 1'b1;
        applyStimulus(m, 1'b0);
        checkBit("t1_busy_capture_done", aBusy, 1'b0);
        checkBit("t1_tvalid_early", aValid, 1'b0);
        @(posedge i_clk); #1;
        checkBit("t1_tvalid_first", aValid, 1'b1);
        checkOutput("t1_first_word", aData, m[0]);
        checkStream("t1", 1'b0);
        checkBit("t1_busy_after", aBusy, 1'b0);

        $display("[TB] toggling tready");
        doReset();
        m = randomMatrix();
        expectMatrix(m);
        tready = 1'b1;
        readyMode = 1;
        applyStimulus(m, 1'b0);
        checkStream("t2", 1'b0);

        $display("[TB] back-to-back matrices");
        doReset();
        m = randomMatrix();
        for (int i = 0; i < 16; i++) m2[i] = m[i] + DW'(100);
        expectMatrix(m);
        expectMatrix(m2);
        tready = 1'b1;
        applyStimulus(m, 1'b0);
        applyStimulus(m2, 1'b0);
        checkStream("t3", 1'b0);
        for (int i = 1; i < cycA.size(); i++)
            checkOutput("t3_gap", DW'(cycA[i] - cycA[i - 1]), DW'(1));

        $display("[TB] reversed row order");
        doReset();
        m = randomMatrix();
        expectMatrix(m);
        tready = 1'b1;
        applyStimulus(m, 1'b1);
        checkStream("t5", 1'b1);

        $display("[TB] overflow with stalled stream");
        doReset();
        tready = 1'b0;
        held = 0;
        for (int j = 0; j < 3; j++) mats[j] = randomMatrix();
        for (int j = 0; j < 3; j++) begin
            checkBit("t4_overflow_before", aOvf, j > 2);
            if (held < 2) begin
                expectMatrix(mats[j]);
                held++;
            end
            applyStimulus(mats[j], 1'b0);
            checkBit("t4_ready", aReady, held < 2);
        end
        checkBit("t4_overflow_set", aOvf, 1'b1);
        repeat (5) @(posedge i_clk);
        #1;
        checkBit("t4_overflow_sticky", aOvf, 1'b1);
        tready = 1'b1;
        checkStream("t4", 1'b0);
        checkBit("t4_overflow_after", aOvf, 1'b1);

        $display("[TB] reset mid-stream");
        obsA.delete(); lastA.delete(); cycA.delete(); expQ.delete();
        m = randomMatrix();
        tready = 1'b1;
        applyStimulus(m, 1'b0);
        waited = 0;
        while (obsA.size() < 7 && waited < 200) begin
            @(posedge i_clk); #1;
            waited++;
        end
        checkBit("t6_reached_beat7", obsA.size() >= 7, 1'b1);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checkBit("t6_tvalid", aValid, 1'b0);
        checkBit("t6_overflow", aOvf, 1'b0);
        checkBit("t6_busy", aBusy, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        obsA.delete(); lastA.delete(); cycA.delete(); expQ.delete();
        m = randomMatrix();
        expectMatrix(m);
        applyStimulus(m, 1'b0);
        checkStream("t6", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
